clk_rst_seq: RTL and testbench

- Parametrised clock/reset sequencer for the system clock domain.
- Qualifies the PLL lock indication and holds all downstream resets until the PLL is stable.
- Releases per-domain active-high resets in a staged order.
- Generates per-channel clock-enable pulses. These replace separate slow clocks: logic runs on clk_sys and is gated by ce[k].
- Sits directly below the clock/reset top and feeds every functional block.

---
 rtl/clk_rst_seq.sv | 156 +++++++++++++++
 tb/tb_clk_rst_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_seq.sv
// rtl/clk_rst_seq.sv - PLL lock qualification, staged per-domain reset release and clock-enable generation
module clk_rst_seq #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 16,
    parameter int LOCK_FILT = 8,
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_GAP = 4
) (
    input  logic                    clk_sys,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic                    soft_rst,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    output logic [NUM_CH-1:0]       ch_rst,
    output logic [NUM_CH-1:0]       ce,
    output logic                    ready,
    output logic [1:0]              state,
    output logic [7:0]              lock_lost_cnt
);

    localparam int FW = $clog2(LOCK_FILT + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int RW = $clog2((NUM_CH - 1) * STAGE_GAP + 2);
    localparam logic [FW-1:0] FILT_LAST = FW'(LOCK_FILT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [RW-1:0] REL_LAST  = RW'((NUM_CH - 1) * STAGE_GAP + 1);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_HOLD = 2'd1,
        S_REL  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [FW-1:0]                   filt_q, filt_d;
    logic [HW-1:0]                   hold_q, hold_d;
    logic [RW-1:0]                   rel_q, rel_d;
    logic [NUM_CH-1:0]               ch_rst_q, ch_rst_d;
    logic [NUM_CH-1:0]               ce_q, ce_d;
    logic                            ready_q, ready_d;
    logic [7:0]                      lost_q, lost_d;
    // Latched divisor minus one, so a counter wraps at dm1 and never needs D itself
    logic [NUM_CH-1:0][DIV_W-1:0]    dm1_q, dm1_d;
    logic [NUM_CH-1:0][DIV_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        filt_d   = filt_q;
        hold_d   = hold_q;
        rel_d    = rel_q;
        ch_rst_d = ch_rst_q;
        ready_d  = ready_q;
        lost_d   = lost_q;
        dm1_d    = dm1_q;
        cnt_d    = cnt_q;
        ce_d     = '0;

        if (state_q == S_WAIT) begin
            ch_rst_d = '1;
            ready_d  = 1'b0;
            if (!pll_locked) begin
                filt_d = '0;
            end else if (filt_q == FILT_LAST) begin
                state_d = S_HOLD;
                filt_d  = '0;
                hold_d  = '0;
            end else begin
                filt_d = filt_q + 1'b1;
            end
        end else if (!pll_locked) begin
            state_d  = S_WAIT;
            filt_d   = '0;
            ch_rst_d = '1;
            ready_d  = 1'b0;
            if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end else if (soft_rst && state_q != S_HOLD) begin
            state_d  = S_HOLD;
            hold_d   = '0;
            ch_rst_d = '1;
            ready_d  = 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_REL;
                        rel_d   = '0;
                        for (int k = 0; k < NUM_CH; k++) begin
                            dm1_d[k] = (div_cfg[k*DIV_W +: DIV_W] == '0) ? '0
                                     : div_cfg[k*DIV_W +: DIV_W] - 1'b1;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_REL: begin
                    rel_d = rel_q + 1'b1;
                    if (rel_d == REL_LAST) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // rel_d counts edges since entering RELEASE; channel k opens at k*STAGE_GAP
        if (state_d == S_REL) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ch_rst_d[k] = (rel_d < RW'(k * STAGE_GAP));
            end
        end

        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_rst_d[k] || ch_rst_q[k]) begin
                cnt_d[k] = '0;
            end else begin
                cnt_d[k] = (cnt_q[k] == dm1_d[k]) ? '0 : cnt_q[k] + 1'b1;
            end
            ce_d[k] = !ch_rst_d[k] && (cnt_d[k] == dm1_d[k]);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q  <= S_WAIT;
            filt_q   <= '0;
            hold_q   <= '0;
            rel_q    <= '0;
            ch_rst_q <= '1;
            ce_q     <= '0;
            ready_q  <= 1'b0;
            lost_q   <= '0;
            dm1_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            filt_q   <= filt_d;
            hold_q   <= hold_d;
            rel_q    <= rel_d;
            ch_rst_q <= ch_rst_d;
            ce_q     <= ce_d;
            ready_q  <= ready_d;
            lost_q   <= lost_d;
            dm1_q    <= dm1_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ch_rst        = ch_rst_q;
    assign ce            = ce_q;
    assign ready         = ready_q;
    assign state         = state_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// tb/tb_clk_rst_seq.sv - directed and randomized checks of clk_rst_seq against a cycle-level reference model
module tb_clk_rst_seq;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;
    localparam int LF     = 8;
    localparam int HC     = 16;
    localparam int GAP    = 4;

    logic                    clk_sys = 1'b0;
    logic                    rst = 1'b1;
    logic                    pll_locked = 1'b0;
    logic                    soft_rst = 1'b0;
    logic [NUM_CH*DIV_W-1:0] div_cfg = '0;
    logic [NUM_CH-1:0]       ch_rst, ce;
    logic                    ready;
    logic [1:0]              state;
    logic [7:0]              lock_lost_cnt;

    clk_rst_seq #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_FILT(LF), .HOLD_CYC(HC), .STAGE_GAP(GAP)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .pll_locked(pll_locked), .soft_rst(soft_rst),
        .div_cfg(div_cfg), .ch_rst(ch_rst), .ce(ce), .ready(ready), .state(state),
        .lock_lost_cnt(lock_lost_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int     n_cmp = 0;
    int     n_bad = 0;
    // Reference model: phase, filter/hold progress, edge index of RELEASE entry, latched divisors
    int     m_st = 0, m_filt = 0, m_hold = 0, m_lost = 0;
    longint cyc = 0, t0 = 0;
    int     m_div [NUM_CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int d;
        cyc++;
        if (rst) begin
            m_st = 0; m_filt = 0; m_hold = 0; m_lost = 0;
        end else if (m_st == 0) begin
            if (pll_locked) begin
                m_filt++;
                if (m_filt == LF) begin m_st = 1; m_hold = 0; m_filt = 0; end
            end else m_filt = 0;
        end else if (!pll_locked) begin
            m_st = 0; m_filt = 0;
            if (m_lost < 255) m_lost++;
        end else if (soft_rst && m_st >= 2) begin
            m_st = 1; m_hold = 0;
        end else if (m_st == 1) begin
            m_hold++;
            if (m_hold == HC) begin
                m_st = 2; t0 = cyc;
                for (int k = 0; k < NUM_CH; k++) begin
                    d = int'(div_cfg[k*DIV_W +: DIV_W]);
                    m_div[k] = (d == 0) ? 1 : d;
                end
            end
        end else if (m_st == 2 && cyc - t0 == (NUM_CH - 1) * GAP + 1) begin
            m_st = 3;
        end
    endtask

    task automatic tick();
        logic [NUM_CH-1:0] e_rst, e_ce;
        longint n;
        model_step();
        @(posedge clk_sys);
        #1;
        n = cyc - t0;
        for (int k = 0; k < NUM_CH; k++) begin
            e_rst[k] = !(m_st >= 2 && n >= k * GAP);
            e_ce[k]  = !e_rst[k] && ((n - k * GAP + 1) % m_div[k] == 0);
        end
        chk("ch_rst", ch_rst, e_rst);
        chk("ce", ce, e_ce);
        chk("ready", ready, m_st == 3);
        chk("state", state, m_st);
        chk("lock_lost_cnt", lock_lost_cnt, m_lost);
    endtask

    task automatic run_to(input int s, input int budget);
        int n = 0;
        while (m_st != s && n < budget) begin tick(); n++; end
        chk("run_to_state", state, s);
    endtask

    int pulses0, pulses1;

    initial begin
        for (int k = 0; k < NUM_CH; k++) m_div[k] = 1;
        div_cfg = {16'd0, 16'd1, 16'd3, 16'd5};

        // Reset, lock-up and staged release
        repeat (3) tick();
        chk("reset_ch_rst", ch_rst, 4'hF);
        chk("reset_state", state, 0);
        rst = 1'b0; pll_locked = 1'b1;
        repeat (7) tick();
        chk("filt_7", state, 0);
        tick();
        chk("hold_after_8", state, 1);
        repeat (15) tick();
        chk("hold_15", state, 1);
        tick();
        chk("release_t0", state, 2);
        chk("t0_ch_rst", ch_rst, 4'b1110);
        for (int k = 1; k < NUM_CH; k++) begin
            repeat (GAP) tick();
            chk("stage_ch_rst", ch_rst, (4'hF << (k + 1)) & 4'hF);
            if (k == 1) chk("first_ce0", ce[0], 1'b1);
        end
        tick();
        chk("run_ready", ready, 1'b1);
        chk("run_state", state, 3);

        // Divisor pulse rates in steady RUN
        pulses0 = 0; pulses1 = 0;
        repeat (15) begin
            tick();
            pulses0 += int'(ce[0]);
            pulses1 += int'(ce[1]);
            chk("ce23_cont", ce[3:2], 2'b11);
        end
        chk("ce0_rate", pulses0, 3);
        chk("ce1_rate", pulses1, 5);

        // Glitchy lock
        rst = 1'b1; tick(); rst = 1'b0;
        repeat (7) tick();
        pll_locked = 1'b0; tick(); pll_locked = 1'b1;
        repeat (7) tick();
        chk("glitch_still_wait", state, 0);
        tick();
        chk("glitch_hold", state, 1);
        chk("glitch_lost0", lock_lost_cnt, 0);

        // Lock loss in RUN, then requalify
        run_to(3, 100);
        pll_locked = 1'b0; tick(); pll_locked = 1'b1;
        chk("loss_ch_rst", ch_rst, 4'hF);
        chk("loss_ce", ce, 4'h0);
        chk("loss_state", state, 0);
        chk("loss_cnt", lock_lost_cnt, 1);
        run_to(3, 100);

        // div_cfg change in RUN ignored until a new pass; soft_rst mid-RELEASE
        div_cfg = {16'd2, 16'd4, 16'd0, 16'd7};
        repeat (20) tick();
        soft_rst = 1'b1; tick(); soft_rst = 1'b0;
        chk("soft_hold", state, 1);
        repeat (HC) tick();
        chk("soft_t0", state, 2);
        repeat (4) tick();
        soft_rst = 1'b1; tick(); soft_rst = 1'b0;
        chk("soft_mid_ch_rst", ch_rst, 4'hF);
        chk("soft_mid_state", state, 1);
        chk("soft_keeps_cnt", lock_lost_cnt, 1);
        run_to(3, 100);
        pulses0 = 0;
        repeat (14) begin tick(); pulses0 += int'(ce[0]); end
        chk("ce0_new_div", pulses0, 2);

        // Priority: lock loss beats soft_rst; rst beats everything
        soft_rst = 1'b1; pll_locked = 1'b0; tick();
        soft_rst = 1'b0; pll_locked = 1'b1;
        chk("prio_state", state, 0);
        chk("prio_cnt", lock_lost_cnt, 2);
        run_to(3, 100);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_run_ch_rst", ch_rst, 4'hF);
        chk("rst_run_ce", ce, 4'h0);
        chk("rst_run_ready", ready, 1'b0);
        chk("rst_run_cnt", lock_lost_cnt, 0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            pll_locked = ($urandom_range(0, 59) != 0);
            soft_rst   = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 99) == 0) begin
                for (int k = 0; k < NUM_CH; k++)
                    div_cfg[k*DIV_W +: DIV_W] = 16'($urandom_range(0, 6));
            end
            tick();
        end
        soft_rst = 1'b0;

        // Saturation of the lock-loss counter
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            repeat (LF) tick();
            pll_locked = 1'b0;
            tick();
        end
        chk("lost_saturate", lock_lost_cnt, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
